// File: rtl/cis_dvp_capture_pkg.sv
// Shared types for the CIS DVP capture path: FSM states, pixel packing constants
// and the FIFO entry layout.
package cis_pkg;

    localparam int PIX_W        = 10;
    localparam int PIX_PER_WORD = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        BLANK   = 2'd2,
        ACTIVE  = 2'd3
    } cis_state_e;

    typedef struct packed {
        logic        sof;
        logic        eol;
        logic [31:0] data;
    } fifo_entry_t;

    function automatic logic [31:0] place_pix(input logic [31:0] word,
                                              input logic [1:0] slot,
                                              input logic [PIX_W-1:0] pix);
        logic [31:0] w;
        w = word;
        case (slot)
            2'd0:    w[9:0]   = pix;
            2'd1:    w[19:10] = pix;
            default: w[29:20] = pix;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/cis_word_fifo.sv
// Generic single-clock FIFO with full/empty flags; head is visible on dout_o.
// A push while full is ignored unless a pop happens in the same cycle.
module cis_word_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 34
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/cis_dvp_capture.sv
// DVP sensor capture: pad synchronisers, frame/line FSM, 3-pixel packer and word FIFO.
// Optional build macro CIS_TEST_PATTERN_EN adds test_pat_i for a synthetic pixel source.
module cis_dvp_capture
    import cis_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter bit VSYNC_ACT_HIGH = 1'b1,
    parameter bit HSYNC_ACT_HIGH = 1'b1,
    parameter int LINE_W         = 12
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,
    input  logic              enable_i,
    input  logic              clr_ovf_i,
    input  logic              cis_pclk_i,
    input  logic              cis_hsync_i,
    input  logic              cis_vsync_i,
    input  logic [9:0]        cis_data_i,
`ifdef CIS_TEST_PATTERN_EN
    input  logic              test_pat_i,
`endif
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [31:0]       m_data_o,
    output logic              m_sof_o,
    output logic              m_eol_o,
    output logic              overflow_o,
    output logic [15:0]       frame_cnt_o,
    output logic [LINE_W-1:0] line_len_o,
    output logic              busy_o
);
    localparam logic HS_IDLE = ~HSYNC_ACT_HIGH;
    localparam logic VS_IDLE = ~VSYNC_ACT_HIGH;

    logic [2:0]       pclk_s_q;
    logic [1:0]       hs_s_q, vs_s_q;
    logic [PIX_W-1:0] data_s1_q, data_s2_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            pclk_s_q  <= '0;
            hs_s_q    <= {2{HS_IDLE}};
            vs_s_q    <= {2{VS_IDLE}};
            data_s1_q <= '0;
            data_s2_q <= '0;
        end else begin
            pclk_s_q  <= {pclk_s_q[1:0], cis_pclk_i};
            hs_s_q    <= {hs_s_q[0], cis_hsync_i};
            vs_s_q    <= {vs_s_q[0], cis_vsync_i};
            data_s1_q <= cis_data_i;
            data_s2_q <= data_s1_q;
        end
    end

    logic pclk_rise, hs_act, vs_act;
    assign pclk_rise = pclk_s_q[1] & ~pclk_s_q[2];
    assign hs_act    = HSYNC_ACT_HIGH ? hs_s_q[1] : ~hs_s_q[1];
    assign vs_act    = VSYNC_ACT_HIGH ? vs_s_q[1] : ~vs_s_q[1];

    cis_state_e        state_q;
    logic [1:0]        slot_q;
    logic [31:0]       word_q, word_d, pend_word_q;
    logic              pend_q, sof_arm_q, hs_prev_q, push_q, ovf_q;
    logic [LINE_W-1:0] pix_cnt_q, line_len_q;
    logic [15:0]       frame_cnt_q;
    fifo_entry_t       push_entry_q, head;
    logic [PIX_W-1:0]  pix_val;
    logic              cap, line_end, frame_start, fifo_full, fifo_empty, pop;

    assign cap         = enable_i && state_q == ACTIVE && pclk_rise && !vs_act && hs_act;
    assign line_end    = enable_i && state_q == ACTIVE && pclk_rise && !vs_act && !hs_act && hs_prev_q;
    assign frame_start = enable_i && state_q == BLANK && pclk_rise && !vs_act;

`ifdef CIS_TEST_PATTERN_EN
    logic [1:0] line_cnt_q;
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n)                  line_cnt_q <= '0;
        else if (!enable_i || frame_start) line_cnt_q <= '0;
        else if (line_end)              line_cnt_q <= line_cnt_q + 2'd1;
    end
    assign pix_val = test_pat_i ? {line_cnt_q, pix_cnt_q[7:0]} : data_s2_q;
`else
    assign pix_val = data_s2_q;
`endif

    // A new word starts from zero so a partial word pushed at line end has clean unused slots.
    assign word_d = place_pix((slot_q == 2'd0) ? 32'd0 : word_q, slot_q, pix_val);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q      <= IDLE;
            slot_q       <= '0;
            word_q       <= '0;
            pend_q       <= 1'b0;
            pend_word_q  <= '0;
            sof_arm_q    <= 1'b0;
            hs_prev_q    <= 1'b0;
            pix_cnt_q    <= '0;
            line_len_q   <= '0;
            frame_cnt_q  <= '0;
            push_q       <= 1'b0;
            push_entry_q <= '0;
        end else begin
            push_q <= 1'b0;
            if (pclk_rise) hs_prev_q <= hs_act;
            if (!enable_i) begin
                state_q   <= IDLE;
                slot_q    <= '0;
                pend_q    <= 1'b0;
                sof_arm_q <= 1'b0;
                pix_cnt_q <= '0;
            end else begin
                case (state_q)
                    IDLE:    state_q <= WAIT_VS;
                    WAIT_VS: if (pclk_rise && vs_act) state_q <= BLANK;
                    BLANK: if (frame_start) begin
                        state_q   <= ACTIVE;
                        sof_arm_q <= 1'b1;
                        slot_q    <= '0;
                        pend_q    <= 1'b0;
                        pix_cnt_q <= '0;
                    end
                    ACTIVE: begin
                        if (pclk_rise && vs_act) begin
                            state_q     <= BLANK;
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                            slot_q      <= '0;
                            pend_q      <= 1'b0;
                            pix_cnt_q   <= '0;
                        end else if (cap) begin
                            if (pix_cnt_q != '1) pix_cnt_q <= pix_cnt_q + 1'b1;
                            // A held full word is not the line's last, so it leaves without eol.
                            if (slot_q == 2'd0 && pend_q) begin
                                push_q       <= 1'b1;
                                push_entry_q <= '{sof: sof_arm_q, eol: 1'b0, data: pend_word_q};
                                sof_arm_q    <= 1'b0;
                            end
                            if (slot_q == 2'(PIX_PER_WORD - 1)) begin
                                pend_q      <= 1'b1;
                                pend_word_q <= word_d;
                                slot_q      <= '0;
                            end else begin
                                pend_q <= 1'b0;
                                word_q <= word_d;
                                slot_q <= slot_q + 2'd1;
                            end
                        end else if (line_end) begin
                            line_len_q <= pix_cnt_q;
                            pix_cnt_q  <= '0;
                            slot_q     <= '0;
                            pend_q     <= 1'b0;
                            if (slot_q != 2'd0) begin
                                push_q       <= 1'b1;
                                push_entry_q <= '{sof: sof_arm_q, eol: 1'b1, data: word_q};
                                sof_arm_q    <= 1'b0;
                            end else if (pend_q) begin
                                push_q       <= 1'b1;
                                push_entry_q <= '{sof: sof_arm_q, eol: 1'b1, data: pend_word_q};
                                sof_arm_q    <= 1'b0;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign pop = m_valid_o & m_ready_i;

    cis_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fifo_entry_t))
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_ni  (wb_rst_n),
        .push_i  (push_q),
        .din_i   (push_entry_q),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n)                        ovf_q <= 1'b0;
        else if (push_q && fifo_full && !pop) ovf_q <= 1'b1;
        else if (clr_ovf_i)                   ovf_q <= 1'b0;
    end

    assign m_valid_o   = ~fifo_empty;
    assign m_data_o    = m_valid_o ? head.data : 32'd0;
    assign m_sof_o     = m_valid_o & head.sof;
    assign m_eol_o     = m_valid_o & head.eol;
    assign overflow_o  = ovf_q;
    assign frame_cnt_o = frame_cnt_q;
    assign line_len_o  = line_len_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_cis_dvp_capture.sv
// Directed bench for cis_dvp_capture: positive- and negative-polarity instances,
// scoreboard queues of {sof, eol, data} popped by per-instance output monitors.
module tb_cis_dvp_capture;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // pads and controls
  logic       enable = 1'b0, enable_n = 1'b0, clr_ovf = 1'b0;
  logic       pclk = 1'b0, hsync = 1'b0, vsync = 1'b0;
  logic [9:0] data = '0;
  logic       hsync_n, vsync_n;
  logic       test_pat = 1'b0;
  assign hsync_n = ~hsync;
  assign vsync_n = ~vsync;

  logic        m_ready = 1'b0, m_ready_n = 1'b1;
  logic        m_valid, m_sof, m_eol, ovf, busy;
  logic [31:0] m_data;
  logic [15:0] frame_cnt;
  logic [11:0] line_len;
  logic        m_valid_n, m_sof_n, m_eol_n, ovf_n, busy_n;
  logic [31:0] m_data_n;
  logic [15:0] frame_cnt_n;
  logic [11:0] line_len_n;

  cis_dvp_capture dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .enable_i(enable), .clr_ovf_i(clr_ovf),
    .cis_pclk_i(pclk), .cis_hsync_i(hsync), .cis_vsync_i(vsync), .cis_data_i(data),
`ifdef CIS_TEST_PATTERN_EN
    .test_pat_i(test_pat),
`endif
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_sof_o(m_sof),
    .m_eol_o(m_eol), .overflow_o(ovf), .frame_cnt_o(frame_cnt), .line_len_o(line_len),
    .busy_o(busy)
  );

  cis_dvp_capture #(.VSYNC_ACT_HIGH(1'b0), .HSYNC_ACT_HIGH(1'b0)) dut_n (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .enable_i(enable_n), .clr_ovf_i(1'b0),
    .cis_pclk_i(pclk), .cis_hsync_i(hsync_n), .cis_vsync_i(vsync_n), .cis_data_i(data),
`ifdef CIS_TEST_PATTERN_EN
    .test_pat_i(test_pat),
`endif
    .m_valid_o(m_valid_n), .m_ready_i(m_ready_n), .m_data_o(m_data_n), .m_sof_o(m_sof_n),
    .m_eol_o(m_eol_n), .overflow_o(ovf_n), .frame_cnt_o(frame_cnt_n), .line_len_o(line_len_n),
    .busy_o(busy_n)
  );

  // scoreboard
  logic [33:0] exp_q[$];
  logic [33:0] exp_n_q[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [33:0] ent(input logic sof, input logic eol,
                                      input logic [9:0] p0, input logic [9:0] p1,
                                      input logic [9:0] p2);
    return {sof, eol, 2'b00, p2, p1, p0};
  endfunction

  always @(negedge clk) begin : mon_dut
    logic [33:0] e;
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL dut_word: unexpected word sof=%0b eol=%0b data=0x%08h, expected none",
                 m_sof, m_eol, m_data);
      end else begin
        e = exp_q.pop_front();
        check("dut_word", {30'd0, m_sof, m_eol, m_data}, {30'd0, e});
      end
    end
  end

  always @(negedge clk) begin : mon_dut_n
    logic [33:0] e;
    if (rst_n && m_valid_n && m_ready_n) begin
      if (exp_n_q.size() == 0) begin
        n_checks++;
        $display("FAIL dutn_word: unexpected word sof=%0b eol=%0b data=0x%08h, expected none",
                 m_sof_n, m_eol_n, m_data_n);
      end else begin
        e = exp_n_q.pop_front();
        check("dutn_word", {30'd0, m_sof_n, m_eol_n, m_data_n}, {30'd0, e});
      end
    end
  end

  // driver tasks: one PICLK period is 8 wb_clk cycles, pads change while PICLK is low
  logic [9:0] line_buf [0:31];

  task automatic pix(input logic hs, input logic vs, input logic [9:0] d);
    hsync = hs;
    vsync = vs;
    data  = d;
    #40 pclk = 1'b1;
    #40 pclk = 1'b0;
  endtask

  task automatic vs_pulse();
    repeat (2) pix(1'b0, 1'b1, 10'd0);
    repeat (2) pix(1'b0, 1'b0, 10'd0);
  endtask

  task automatic send_line(input int n);
    for (int i = 0; i < n; i++) pix(1'b1, 1'b0, line_buf[i]);
    repeat (2) pix(1'b0, 1'b0, 10'd0);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 m_ready = r;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", m_valid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_line_len", line_len, 0);
    check("rst_busy", busy, 0);
    check("rst_data", m_data, 0);
    rst_n = 1'b1;

    // first frame, 6-pixel line
    enable = 1'b1;
    set_ready(1'b1);
    #50;
    check("busy_enabled", busy, 1);
    vs_pulse();
    for (int i = 0; i < 6; i++) line_buf[i] = 10'(i + 1);
    exp_q.push_back({1'b1, 1'b0, 32'h00300801});
    exp_q.push_back({1'b0, 1'b1, 32'h00601404});
    send_line(6);
    #200;
    check("line_len_6", line_len, 6);

    // 4-pixel line with a partial last word
    line_buf[0] = 10'h3FF; line_buf[1] = 10'h3FE; line_buf[2] = 10'h3FD; line_buf[3] = 10'h3FC;
    exp_q.push_back({1'b0, 1'b0, 32'h3FDFFBFF});
    exp_q.push_back({1'b0, 1'b1, 32'h000003FC});
    send_line(4);
    #200;
    check("line_len_4", line_len, 4);
    check("frame_cnt_0", frame_cnt, 0);

    // back-pressure: two 8-word lines into an 8-deep FIFO
    set_ready(1'b0);
    vs_pulse();
    #100;
    check("frame_cnt_1", frame_cnt, 1);
    for (int i = 0; i < 24; i++) line_buf[i] = 10'(10'h100 + i);
    for (int w = 0; w < 8; w++)
      exp_q.push_back(ent(w == 0, w == 7, line_buf[3*w], line_buf[3*w+1], line_buf[3*w+2]));
    send_line(24);
    #100;
    check("ovf_exact_full", ovf, 0);
    for (int i = 0; i < 24; i++) line_buf[i] = 10'(10'h200 + i);
    send_line(24);
    #200;
    check("ovf_set", ovf, 1);
    check("bp_valid_held", m_valid, 1);
    check("bp_data_held", m_data, {2'b00, 10'h102, 10'h101, 10'h100});
    check("bp_sof_held", m_sof, 1);
    @(posedge clk); #1 clr_ovf = 1'b1;
    @(posedge clk); #1 clr_ovf = 1'b0;
    #1;
    check("ovf_cleared", ovf, 0);
    set_ready(1'b1);
    #400;
    check("bp_drained", exp_q.size(), 0);

    // enable asserted mid-frame: nothing until the next VSYNC
    vs_pulse();
    #100;
    check("frame_cnt_2", frame_cnt, 2);
    enable = 1'b0;
    #50;
    check("busy_disabled", busy, 0);
    for (int i = 0; i < 3; i++) pix(1'b1, 1'b0, 10'(10'h0A0 + i));
    enable = 1'b1;
    for (int i = 0; i < 3; i++) pix(1'b1, 1'b0, 10'(10'h0B0 + i));
    repeat (2) pix(1'b0, 1'b0, 10'd0);
    vs_pulse();
    #100;
    check("frame_cnt_no_inc", frame_cnt, 2);
    line_buf[0] = 10'h011; line_buf[1] = 10'h022; line_buf[2] = 10'h033;
    exp_q.push_back({1'b1, 1'b1, 32'h03308811});
    send_line(3);
    #200;
    check("line_len_3", line_len, 3);
    vs_pulse();
    #100;
    check("frame_cnt_3", frame_cnt, 3);

    // enable dropped mid-line while words are buffered
    set_ready(1'b0);
    for (int i = 0; i < 6; i++) line_buf[i] = 10'(10'h040 + i);
    exp_q.push_back(ent(1'b1, 1'b0, 10'h040, 10'h041, 10'h042));
    exp_q.push_back(ent(1'b0, 1'b1, 10'h043, 10'h044, 10'h045));
    send_line(6);
    pix(1'b1, 1'b0, 10'h050);
    pix(1'b1, 1'b0, 10'h051);
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("busy_drop", busy, 0);
    pix(1'b1, 1'b0, 10'h052);
    repeat (2) pix(1'b0, 1'b0, 10'd0);
    #100;
    check("drop_buffered_valid", m_valid, 1);
    set_ready(1'b1);
    #300;

    // inverted-polarity instance sees the same words
    enable = 1'b1;
    enable_n = 1'b1;
    #100;
    vs_pulse();
    line_buf[0] = 10'h001; line_buf[1] = 10'h002; line_buf[2] = 10'h003;
    exp_q.push_back({1'b1, 1'b1, 32'h00300801});
    exp_n_q.push_back({1'b1, 1'b1, 32'h00300801});
    send_line(3);
    #200;
    check("frame_cnt_after_reenable", frame_cnt, 3);
    check("n_line_len_3", line_len_n, 3);
    check("n_busy", busy_n, 1);

`ifdef CIS_TEST_PATTERN_EN
    // synthetic pattern on line 0 of a new frame
    test_pat = 1'b1;
    vs_pulse();
    for (int i = 0; i < 3; i++) line_buf[i] = 10'($urandom_range(0, 1023));
    exp_q.push_back({1'b1, 1'b1, 32'h00200400});
    exp_n_q.push_back({1'b1, 1'b1, 32'h00200400});
    send_line(3);
    #200;
    test_pat = 1'b0;
`endif

    for (int i = 0; i < 2000 && (exp_q.size() != 0 || exp_n_q.size() != 0); i++) @(posedge clk);
    #1;
    check("final_exp_q_empty", exp_q.size(), 0);
    check("final_exp_n_q_empty", exp_n_q.size(), 0);
    check("final_ovf_n", ovf_n, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
